// File: rtl/mem_access_unit.sv
// mem_access_unit
// Bridges a single-outstanding CPU load/store request onto a 64-byte data
// RAM port.  Illegal requests get an immediate error response without any
// RAM access.  The RAM read latency is 1 + DELAY cycles.
// Optional feature: define MAU_ALIGN_CHECK_EN to reject misaligned half and
// word accesses.  Without it, misaligned accesses go to the RAM unmodified.
module mem_access_unit #(
    parameter int BIT_WIDTH = 32,
    parameter int DELAY     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [31:0]          req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [BIT_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [BIT_WIDTH-1:0] ram_data,
    output logic [5:0]           ram_addr,
    output logic                 ram_wren,
    output logic                 ram_isSigned,
    output logic [1:0]           ram_dataSize,
    input  logic [BIT_WIDTH-1:0] ram_q,
    output logic                 busy
);

    // The WAIT counter only has to reach DELAY.
    localparam int CW = (DELAY < 1) ? 1 : $clog2(DELAY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q;
    logic                   req_ready_q;
    logic                   wr_q;
    logic [CW-1:0]          cnt_q;
    logic                   resp_valid_q;
    logic                   resp_err_q;
    logic [BIT_WIDTH-1:0]   resp_rdata_q;
    logic [BIT_WIDTH-1:0]   ram_data_q;
    logic [5:0]             ram_addr_q;
    logic                   ram_wren_q;
    logic                   ram_signed_q;
    logic [1:0]             ram_size_q;
    logic                   req_err_d;

    // Decide whether the presented request is illegal (out of range, reserved size, optionally misaligned).
    always_comb begin
        req_err_d = (|req_addr[31:6]) || (req_size == 2'b11);
`ifdef MAU_ALIGN_CHECK_EN
        if ((req_size == 2'b01) && req_addr[0])
            req_err_d = 1'b1;
        if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
            req_err_d = 1'b1;
`else
        req_err_d = req_err_d;
`endif
    end

    // Access sequencer: accepts a request, strobes or reads the RAM, then holds the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            ram_data_q   <= '0;
            ram_addr_q   <= '0;
            ram_wren_q   <= 1'b0;
            ram_signed_q <= 1'b0;
            ram_size_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        wr_q        <= req_wr;
                        if (req_err_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q      <= ISSUE;
                            ram_addr_q   <= req_addr[5:0];
                            ram_size_q   <= req_size;
                            ram_signed_q <= req_signed;
                            ram_data_q   <= req_wdata;
                            ram_wren_q   <= req_wr;
                        end
                    end
                end
                ISSUE: begin
                    ram_wren_q <= 1'b0;
                    cnt_q      <= '0;
                    if (wr_q) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CW'(DELAY)) begin
                        state_q      <= RESP;
                        cnt_q        <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= ram_q;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_rdata   = resp_rdata_q;
    assign ram_data     = ram_data_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wren     = ram_wren_q;
    assign ram_isSigned = ram_signed_q;
    assign ram_dataSize = ram_size_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit, built with DELAY=2.
// Expected values are hand-computed from the access rules.  The results
// depend on MAU_ALIGN_CHECK_EN when a misaligned half-word is loaded.
module tb_mem_access_unit;

    localparam int BW    = 32;
    localparam int DELAY = 2;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [31:0]   req_addr;
    logic [BW-1:0] req_wdata;
    logic [1:0]    req_size;
    logic          req_signed;
    logic          resp_valid;
    logic          resp_ready;
    logic [BW-1:0] resp_rdata;
    logic          resp_err;
    logic [BW-1:0] ram_data;
    logic [5:0]    ram_addr;
    logic          ram_wren;
    logic          ram_isSigned;
    logic [1:0]    ram_dataSize;
    logic [BW-1:0] ram_q;
    logic          busy;

    int testsRun    = 0;
    int testsFailed = 0;

    mem_access_unit #(.BIT_WIDTH(BW), .DELAY(DELAY)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_wren(ram_wren),
        .ram_isSigned(ram_isSigned), .ram_dataSize(ram_dataSize),
        .ram_q(ram_q), .busy(busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Run one access with resp_ready high.  Record latency in edges from acceptance, the response, and RAM activity.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic sgn,
                                 output int lat, output logic [31:0] rdata, output logic err,
                                 output int wrenCnt, output logic [5:0] addrSeen,
                                 output logic [1:0] sizeSeen, output logic [31:0] dataSeen,
                                 output logic sgnSeen);
        int waitCnt;
        lat = -1; rdata = 'x; err = 'x; wrenCnt = 0;
        resp_ready = 1'b1;
        req_wr = wr; req_addr = addr; req_wdata = wdata; req_size = size; req_signed = sgn;
        req_valid = 1'b1;
        waitCnt = 0;
        while (!req_ready && waitCnt < 10) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!req_ready) begin
            checkOutput("reqReadyTimeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            addrSeen = 'x; sizeSeen = 'x; dataSeen = 'x; sgnSeen = 'x;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        addrSeen = ram_addr; sizeSeen = ram_dataSize; dataSeen = ram_data; sgnSeen = ram_isSigned;
        for (int n = 1; n <= 20; n++) begin
            if (ram_wren) wrenCnt++;
            if (resp_valid) begin
                lat = n; rdata = resp_rdata; err = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    int          lat, wc;
    logic [31:0] rd, dSeen;
    logic        er, sSeen;
    logic [5:0]  aSeen;
    logic [1:0]  zSeen;
    bit          sawResp;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_signed = 1'b0; resp_ready = 1'b1; ram_q = '0;

        // Reset values
        #3;
        checkOutput("rstReqReady",  32'(req_ready),  32'd0);
        checkOutput("rstRespValid", 32'(resp_valid), 32'd0);
        checkOutput("rstBusy",      32'(busy),       32'd0);
        checkOutput("rstWren",      32'(ram_wren),   32'd0);
        checkOutput("rstRamAddr",   32'(ram_addr),   32'd0);
        #9 rst_n = 1'b1;
        #1;
        checkOutput("reqReadyBeforeClk", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("reqReadyAfterClk", 32'(req_ready), 32'd1);

        // Store word 0xDEADBEEF to 0x10
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, lat, rd, er, wc, aSeen, zSeen, dSeen, sSeen);
        checkOutput("stLatency", 32'(lat),   32'd2);
        checkOutput("stWrenCnt", 32'(wc),    32'd1);
        checkOutput("stRamAddr", 32'(aSeen), 32'h10);
        checkOutput("stRamSize", 32'(zSeen), 32'd2);
        checkOutput("stRamData", dSeen,      32'hDEADBEEF);
        checkOutput("stErr",     32'(er),    32'd0);
        checkOutput("stRdata",   rd,         32'd0);

        // Signed byte load from 0x13
        ram_q = 32'hFFFFFF80;
        applyStimulus(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, lat, rd, er, wc, aSeen, zSeen, dSeen, sSeen);
        checkOutput("ldLatency", 32'(lat),   32'(DELAY + 3));
        checkOutput("ldRdata",   rd,         32'hFFFFFF80);
        checkOutput("ldWrenCnt", 32'(wc),    32'd0);
        checkOutput("ldRamAddr", 32'(aSeen), 32'h13);
        checkOutput("ldSigned",  32'(sSeen), 32'd1);
        checkOutput("ldErr",     32'(er),    32'd0);

        // Out-of-range word load from 0x40
        applyStimulus(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, lat, rd, er, wc, aSeen, zSeen, dSeen, sSeen);
        checkOutput("oorLatency", 32'(lat), 32'd1);
        checkOutput("oorErr",     32'(er),  32'd1);
        checkOutput("oorRdata",   rd,       32'd0);
        checkOutput("oorWrenCnt", 32'(wc),  32'd0);

        // Reserved size store at 0x00
        applyStimulus(1'b1, 32'h00, 32'h55, 2'b11, 1'b0, lat, rd, er, wc, aSeen, zSeen, dSeen, sSeen);
        checkOutput("rsvErr",     32'(er), 32'd1);
        checkOutput("rsvWrenCnt", 32'(wc), 32'd0);

        // Misaligned half load from 0x01
        ram_q = 32'h0000ABCD;
        applyStimulus(1'b0, 32'h01, 32'h0, 2'b01, 1'b0, lat, rd, er, wc, aSeen, zSeen, dSeen, sSeen);
`ifdef MAU_ALIGN_CHECK_EN
        checkOutput("misErr",     32'(er),  32'd1);
        checkOutput("misLatency", 32'(lat), 32'd1);
        checkOutput("misRdata",   rd,       32'd0);
`else
        checkOutput("misErr",     32'(er),    32'd0);
        checkOutput("misRamAddr", 32'(aSeen), 32'h01);
        checkOutput("misRamSize", 32'(zSeen), 32'd1);
        checkOutput("misRdata",   rd,         32'h0000ABCD);
`endif

        // Response held for 4 cycles with resp_ready low
        @(posedge clk); #1;
        ram_q = 32'h12345678;
        resp_ready = 1'b0;
        req_wr = 1'b0; req_addr = 32'h08; req_size = 2'b10; req_signed = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 0; n < 20 && !resp_valid; n++) begin
            @(posedge clk); #1;
        end
        ram_q = 32'h0;
        for (int n = 0; n < 4; n++) begin
            checkOutput("holdValid",    32'(resp_valid), 32'd1);
            checkOutput("holdRdata",    resp_rdata,      32'h12345678);
            checkOutput("holdReqReady", 32'(req_ready),  32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("relValid",    32'(resp_valid), 32'd0);
        checkOutput("relReqReady", 32'(req_ready),  32'd1);
        checkOutput("relBusy",     32'(busy),       32'd0);

        // Reset during WAIT of a load aborts it
        req_wr = 1'b0; req_addr = 32'h04; req_size = 2'b10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("waitBusy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abortBusy",     32'(busy),       32'd0);
        checkOutput("abortValid",    32'(resp_valid), 32'd0);
        checkOutput("abortReqReady", 32'(req_ready),  32'd0);
        #2 rst_n = 1'b1;
        sawResp = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (resp_valid) sawResp = 1'b1;
        end
        checkOutput("abortNoResp", 32'(sawResp), 32'd0);

        // Reset during ISSUE of a store drops ram_wren at once
        req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE; req_size = 2'b10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("issueWren", 32'(ram_wren), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("issueRstWren", 32'(ram_wren), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("postRstReqReady", 32'(req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: BIT_WIDTH, default 32, data width; DELAY, default 0, extra RAM read-latency cycles beyond one.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU presents an access.
REQ-005 req_ready  output  1  unit accepts the access this cycle.
REQ-006 req_wr  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  BIT_WIDTH  store data, right-justified.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 req_signed  input  1  sign-extend load result.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  CPU takes the response.
REQ-013 resp_rdata  output  BIT_WIDTH  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  access rejected, no RAM access made.
REQ-015 ram_data, ram_addr, ram_wren, ram_isSigned, ram_dataSize  outputs  BIT_WIDTH/6/1/1/2  drive data RAM port.
REQ-016 ram_q  input  BIT_WIDTH  data RAM read result.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: req_ready=1; on req_valid&req_ready the request SHALL be latched and the access checked in the same cycle.
REQ-020 Error if req_addr[31:6]!=0 or req_size==11 (plus alignment, see REQ-031): next state RESP with resp_err=1, resp_rdata=0, no RAM strobe.
REQ-021 Legal access: next state ISSUE; ram_addr=addr[5:0], ram_dataSize=size, ram_isSigned=signed, ram_data=wdata, held stable from ISSUE until leaving WAIT.
REQ-022 ISSUE lasts exactly one cycle; ram_wren=1 only in ISSUE and only for stores.
REQ-023 Store: ISSUE -> RESP.
REQ-024 Load: ISSUE -> WAIT; WAIT SHALL count DELAY+1 cycles, then capture ram_q into resp_rdata and go to RESP (DELAY=0: one WAIT cycle).
REQ-025 RESP: resp_valid=1, outputs stable until resp_ready=1; on resp_valid&resp_ready -> IDLE, resp_valid and resp_err drop next cycle.
REQ-026 req_ready SHALL be 0 outside IDLE; new requests are not accepted in the cycle RESP completes (one idle cycle minimum between accesses).
REQ-027 Load-to-response latency with resp_ready held high: DELAY+3 cycles from acceptance edge; store: 2 cycles; error: 1 cycle.
REQ-028 ram_wren SHALL never assert for an errored request or outside ISSUE.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, req_ready=0 while asserted, resp_valid=0, resp_err=0, resp_rdata=0, ram_wren=0, all other ram_* outputs 0, busy=0, WAIT counter 0.
REQ-030 Reset mid-access SHALL abort it with no response; a store reset during ISSUE deasserts ram_wren asynchronously; req_ready=1 from the first clock after rst_n rises.

Configuration
REQ-031 Macro MAU_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL be an error per REQ-020; undefined: no alignment check, misaligned accesses pass to RAM unmodified.

Verification
REQ-032 Store word 0xDEADBEEF to 0x10, resp_ready=1 -> ram_wren high one cycle with ram_addr=0x10, ram_dataSize=10; resp_valid 2 cycles after accept, resp_err=0.
REQ-033 DELAY=2, load byte signed from 0x13, ram_q=0xFFFFFF80 -> resp_rdata=0xFFFFFF80 5 cycles after accept, no ram_wren.
REQ-034 Load word from 0x40 -> resp_err=1, resp_rdata=0, resp_valid next cycle, ram_wren never high.
REQ-035 req_size=11 at 0x00 -> error response; with MAU_ALIGN_CHECK_EN, load half at 0x01 -> error; without it, RAM access at ram_addr=0x01.
REQ-036 Hold resp_ready=0 for 4 cycles in RESP -> resp_valid/resp_rdata stable, req_ready=0; release -> IDLE, req_ready=1 following cycle.
REQ-037 Assert rst_n=0 in WAIT of a load -> busy=0, resp_valid=0 immediately; no response after release.
